rs_encoder_256: RTL and testbench



---
 rtl/rs_encoder_256.sv | 168 ++++++++++++++++
 tb/tb_rs_encoder_256.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder_256.sv
// Systematic Reed-Solomon encoder over GF(256): forwards the message, then appends NPAR parity symbols.
// Optional build macro RS_ENC_LEN_CHECK_EN rejects starts with an illegal msg_len and pulses err.
module rs_encoder_256 #(
    parameter int unsigned NPAR      = 16,
    parameter logic [8:0]  PRIM_POLY = 9'h11D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] msg_len,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    input  logic       ready_out,
    output logic       last_out,
    output logic       busy,
    output logic       err
);

    localparam int unsigned SW = 8;
    localparam int unsigned CW = 8;

    // Shift-and-reduce multiply in GF(2^8)
    function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] acc;
        logic [SW-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < int'(SW); i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[SW-1] ? ({sh[SW-2:0], 1'b0} ^ PRIM_POLY[SW-1:0]) : {sh[SW-2:0], 1'b0};
        end
        return acc;
    endfunction

    // g(x) = prod (x + alpha^i); monic term dropped, coefficient j in bits [j*SW +: SW]
    function automatic logic [NPAR*SW-1:0] gen_poly();
        logic [(NPAR+1)*SW-1:0] c;
        logic [SW-1:0]          root;
        c          = '0;
        c[SW-1:0]  = 8'h01;
        root       = 8'h01;
        for (int i = 0; i < int'(NPAR); i++) begin
            for (int j = int'(NPAR); j > 0; j--)
                c[j*SW +: SW] = c[(j-1)*SW +: SW] ^ gf_mul(c[j*SW +: SW], root);
            c[SW-1:0] = gf_mul(c[SW-1:0], root);
            root      = gf_mul(root, 8'h02);
        end
        return c[NPAR*SW-1:0];
    endfunction

    localparam logic [NPAR*SW-1:0] GEN = gen_poly();

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] p     [NPAR];
    logic [SW-1:0] p_fb  [NPAR];
    logic [SW-1:0] fb;
    logic [CW-1:0] k_len;
    logic [CW-1:0] count;
    logic          len_ok;
    logic          slot_free;
    logic          start_ok;
    logic          msg_acc;
    logic          msg_last;
    logic          par_emit;
    logic          par_done;

`ifdef RS_ENC_LEN_CHECK_EN
    assign len_ok = (msg_len != '0) && (msg_len <= CW'(255 - NPAR));
`else
    assign len_ok = 1'b1;
`endif

    assign msg_last = (count == CW'(k_len - CW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = (msg_len == '0) ? PAR : MSG;
            MSG:     if (msg_acc && msg_last) state_nxt = PAR;
            PAR:     if (par_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and datapath strobes
    always_comb begin
        slot_free = !valid_out || ready_out;
        ready_in  = 1'b0;
        start_ok  = 1'b0;
        msg_acc   = 1'b0;
        par_emit  = 1'b0;
        par_done  = 1'b0;
        case (state)
            IDLE: start_ok = start && len_ok;
            MSG: begin
                ready_in = slot_free;
                msg_acc  = valid_in && slot_free;
            end
            PAR: begin
                par_emit = slot_free && (count < CW'(NPAR));
                par_done = slot_free && valid_out && last_out;
            end
            default: ;
        endcase
    end

    // LFSR division step for the symbol on data_in
    always_comb begin
        fb      = data_in ^ p[NPAR-1];
        p_fb[0] = gf_mul(fb, GEN[0 +: SW]);
        for (int j = 1; j < int'(NPAR); j++)
            p_fb[j] = p[j-1] ^ gf_mul(fb, GEN[j*SW +: SW]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            busy      <= 1'b0;
            k_len     <= '0;
            count     <= '0;
            for (int j = 0; j < int'(NPAR); j++) p[j] <= '0;
        end else if (start_ok) begin
            k_len <= msg_len;
            count <= '0;
            busy  <= 1'b1;
            for (int j = 0; j < int'(NPAR); j++) p[j] <= '0;
        end else if (msg_acc) begin
            data_out  <= data_in;
            valid_out <= 1'b1;
            count     <= msg_last ? '0 : CW'(count + CW'(1));
            for (int j = 0; j < int'(NPAR); j++) p[j] <= p_fb[j];
        end else if (par_emit) begin
            data_out  <= p[NPAR-1];
            valid_out <= 1'b1;
            last_out  <= (count == CW'(NPAR - 1));
            count     <= CW'(count + CW'(1));
            p[0]      <= '0;
            for (int j = 1; j < int'(NPAR); j++) p[j] <= p[j-1];
        end else if (slot_free) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            if (par_done) busy <= 1'b0;
        end
    end

`ifdef RS_ENC_LEN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= (state == IDLE) && start && !len_ok;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rs_encoder_256.sv
// Bench for rs_encoder_256: NPAR=2 and NPAR=16 instances checked against a polynomial long-division
// model and zero syndromes, with stalls, mid-codeword reset and start-length handling.
module tb_rs_encoder_256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, start16;
    logic [7:0] msg_len, data_in;
    logic       valid_in, ready_out;
    logic [7:0] d2, d16;
    logic       v2, v16, l2, l16, b2, b16, e2, e16, ri2, ri16;

    always #5 clk = ~clk;

    rs_encoder_256 #(.NPAR(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .msg_len(msg_len), .data_in(data_in),
        .valid_in(valid_in), .ready_in(ri2), .data_out(d2), .valid_out(v2),
        .ready_out(ready_out), .last_out(l2), .busy(b2), .err(e2));

    rs_encoder_256 #(.NPAR(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .msg_len(msg_len), .data_in(data_in),
        .valid_in(valid_in), .ready_in(ri16), .data_out(d16), .valid_out(v16),
        .ready_out(ready_out), .last_out(l16), .busy(b16), .err(e16));

    bit         cur_sel;
    logic [7:0] obs_data;
    logic       obs_valid, obs_last, obs_busy, obs_rdy;
    assign obs_data  = cur_sel ? d16  : d2;
    assign obs_valid = cur_sel ? v16  : v2;
    assign obs_last  = cur_sel ? l16  : l2;
    assign obs_busy  = cur_sel ? b16  : b2;
    assign obs_rdy   = cur_sel ? ri16 : ri2;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] alog [0:254];
    logic [7:0] glog [0:255];
    logic [7:0] msg  [0:255];
    logic [7:0] mpar [0:31];
    logic [7:0] got  [$];
    logic [7:0] prev [$];
    int         run_cycles;
    int         last_pos;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return alog[(int'(glog[a]) + int'(glog[b])) % 255];
    endfunction

    // Remainder of m(x)*x^npar divided by g(x), by long division; highest order first
    task automatic model_parity(input int k, input int npar);
        logic [7:0] g  [0:32];
        logic [7:0] dv [0:287];
        logic [7:0] c;
        for (int i = 0; i <= 32; i++) g[i] = 8'h00;
        g[0] = 8'h01;
        for (int r = 0; r < npar; r++) begin
            for (int j = r + 1; j > 0; j--) g[j] = g[j-1] ^ gmul(g[j], alog[r]);
            g[0] = gmul(g[0], alog[r]);
        end
        for (int i = 0; i < 288; i++) dv[i] = (i < k) ? msg[i] : 8'h00;
        for (int i = 0; i < k; i++) begin
            c = dv[i];
            for (int j = 1; j <= npar; j++) dv[i+j] = dv[i+j] ^ gmul(c, g[npar-j]);
        end
        for (int j = 0; j < npar; j++) mpar[j] = dv[k+j];
    endtask

    function automatic logic [7:0] syndrome(input int i);
        logic [7:0] s = 8'h00;
        foreach (got[n]) s = gmul(s, alog[i]) ^ got[n];
        return s;
    endfunction

    // Drive one codeword on the selected instance, collecting accepted output beats
    task automatic run_cw(input bit sel, input int k, input bit stall, input bit dup);
        int         idx = 0;
        int         cyc = 0;
        bit         done = 0;
        bit         held = 0;
        logic [7:0] hd = 8'h00;
        logic       hl = 1'b0;
        cur_sel  = sel;
        got.delete();
        last_pos = -1;
        @(negedge clk);
        msg_len   = 8'(k);
        start2    = !sel;
        start16   = sel;
        valid_in  = 1'b1;
        data_in   = msg[0];
        ready_out = 1'b1;
        #1 chk("idle_ready_in", 32'(obs_rdy), 32'd0);
        @(negedge clk);
        start2  = 1'b0;
        start16 = 1'b0;
        chk("busy_after_start", 32'(obs_busy), 32'd1);
        while (!done && cyc < 3000) begin
            if (held) begin
                chk("stall_data", 32'(obs_data), 32'(hd));
                chk("stall_last", 32'(obs_last), 32'(hl));
            end
            ready_out = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            valid_in  = (idx < k) && (!stall || $urandom_range(0, 4) != 0);
            data_in   = valid_in ? msg[idx] : 8'h00;
            msg_len   = dup ? 8'd5 : 8'(k);
            start16   = dup && sel && cyc == 5;
            start2    = dup && !sel && cyc == 5;
            #1;
            if (obs_valid && !ready_out) chk("stall_ready_in", 32'(obs_rdy), 32'd0);
            held = obs_valid && !ready_out;
            hd   = obs_data;
            hl   = obs_last;
            if (valid_in && obs_rdy) idx++;
            if (obs_valid && ready_out) begin
                got.push_back(obs_data);
                if (obs_last) begin
                    last_pos = got.size() - 1;
                    done     = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start2 = 1'b0; start16 = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        if (!done) chk("codeword_timeout", 32'(cyc), 32'd0);
        run_cycles = cyc;
        chk("busy_drop", 32'(obs_busy), 32'd0);
        chk("valid_drop", 32'(obs_valid), 32'd0);
    endtask

    // Compare the collected stream with message + model parity and check syndromes
    task automatic check_cw(input bit sel, input int k, input bit stall);
        int npar = sel ? 16 : 2;
        int bad  = -1;
        model_parity(k, npar);
        chk("stream_len", 32'(got.size()), 32'(k + npar));
        chk("last_pos", 32'(last_pos), 32'(k + npar - 1));
        for (int i = 0; i < got.size() && i < k + npar; i++)
            if (bad < 0 && got[i] !== ((i < k) ? msg[i] : mpar[i-k])) bad = i;
        chk("first_bad_symbol", 32'(bad), 32'hFFFF_FFFF);
        for (int i = 0; i < npar; i++) begin
            if (syndrome(i) !== 8'h00) begin
                chk("syndrome_zero", 32'(syndrome(i)), 32'd0);
                break;
            end
        end
        if (!stall) chk("throughput_cycles", 32'(run_cycles), 32'(k + npar + 1));
    endtask

    typedef struct {
        bit         sel;
        int         k;
        int         kind;     // 0 explicit, 1 zeros, 2 ramp, 3 random, 4 reuse previous
        bit         stall;
        bit         dup;
        logic [7:0] m0, m1;
        bit         chk_par;
        logic [7:0] p0, p1;   // expected first two parity symbols
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [7:0] a;
        a = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = a;
            glog[a] = 8'(i);
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
        end
        glog[0] = 8'h00;

        vecs[0]  = '{0, 1, 0, 0, 0, 8'h01, 8'h00, 1, 8'h03, 8'h02};
        vecs[1]  = '{0, 1, 0, 0, 0, 8'h02, 8'h00, 1, 8'h06, 8'h04};
        vecs[2]  = '{0, 2, 0, 0, 0, 8'h01, 8'h00, 1, 8'h07, 8'h06};
        vecs[3]  = '{0, 2, 0, 0, 0, 8'h01, 8'h01, 1, 8'h04, 8'h04};
        vecs[4]  = '{0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 8'h00};
        vecs[5]  = '{1, 239, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        vecs[6]  = '{1, 4, 2, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        vecs[7]  = '{1, 60, 3, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        vecs[8]  = '{1, 60, 4, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        vecs[9]  = '{1, 239, 3, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        vecs[10] = '{1, 10, 3, 1, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        vecs[11] = '{0, 20, 3, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};

        rst_n = 1'b0; start2 = 1'b0; start16 = 1'b0; msg_len = 8'h00;
        data_in = 8'h00; valid_in = 1'b0; ready_out = 1'b1; cur_sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data_out", 32'({d2, d16}), 32'd0);
        chk("rst_valid_last", 32'({v2, v16, l2, l16}), 32'd0);
        chk("rst_busy_err_rdy", 32'({b2, b16, e2, e16, ri2, ri16}), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < vecs[v].k; i++) begin
                case (vecs[v].kind)
                    0:       msg[i] = (i == 0) ? vecs[v].m0 : vecs[v].m1;
                    1:       msg[i] = 8'h00;
                    2:       msg[i] = 8'(i + 1);
                    3:       msg[i] = 8'($urandom_range(0, 255));
                    default: ;
                endcase
            end
            run_cw(vecs[v].sel, vecs[v].k, vecs[v].stall, vecs[v].dup);
            check_cw(vecs[v].sel, vecs[v].k, vecs[v].stall);
            if (vecs[v].chk_par && got.size() >= vecs[v].k + 2) begin
                chk("table_parity0", 32'(got[vecs[v].k]), 32'(vecs[v].p0));
                chk("table_parity1", 32'(got[vecs[v].k + 1]), 32'(vecs[v].p1));
            end
            if (vecs[v].kind == 4) begin
                chk("stall_stream_len", 32'(got.size()), 32'(prev.size()));
                for (int i = 0; i < got.size() && i < prev.size(); i++)
                    if (got[i] !== prev[i]) begin
                        chk("stall_vs_nostall", 32'(got[i]), 32'(prev[i]));
                        break;
                    end
            end
            prev = got;
        end

        // Reset three symbols into a ten-symbol codeword
        cur_sel = 1'b1;
        @(negedge clk);
        msg_len = 8'd10; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; data_in = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        valid_in = 1'b0;
        chk("pre_reset_valid", 32'(v16), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_data_out", 32'(d16), 32'd0);
        chk("abort_flags", 32'({v16, l16, b16, e16, ri16}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        msg[0] = 8'h01;
        run_cw(1'b0, 1, 1'b0, 1'b0);
        chk("post_reset_len", 32'(got.size()), 32'd3);
        if (got.size() == 3) chk("post_reset_stream", 32'({got[0], got[1], got[2]}), 32'h010302);

`ifdef RS_ENC_LEN_CHECK_EN
        cur_sel = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            msg_len = (t == 0) ? 8'd240 : 8'd0; start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            chk("len_reject_err", 32'(e16), 32'd1);
            chk("len_reject_busy", 32'(b16), 32'd0);
            @(negedge clk);
            chk("len_reject_err_pulse", 32'(e16), 32'd0);
        end
`else
        run_cw(1'b1, 0, 1'b0, 1'b0);
        check_cw(1'b1, 0, 1'b0);
        chk("err_tied_low", 32'({e2, e16}), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
